cordic_fix2fp_pipe: RTL and testbench
=====================================

Name: cordic_fix2fp_pipe

Overview:
Pipelined converter that turns the unsigned Q1.31 magnitude produced by the CORDIC core, plus a sign bit, into an IEEE-754 single-precision value. It replaces the single-cycle combinational normaliser that sits after the rotation loop. The converter does proper leading-one detection and round-to-nearest-even, and supports valid/ready flow control. It sits directly downstream of the CORDIC iteration datapath and feeds the custom-instruction result register.

Parameters:
FIX_W, 32, width of fixed-point input; binary point after MSB (Q1.(FIX_W-1))
EXP_BIAS, 127, IEEE exponent bias

Ports:
clock  in  1  single clock, all state on rising edge
aclr_n  in  1  synchronous active-low reset
clk_en  in  1  global enable; when low, no state changes
in_valid  in  1  fix_in/sign_in valid
in_ready  out  1  converter accepts input this cycle
fix_in  in  FIX_W  unsigned magnitude, Q1.31 (0x80000000 = 1.0)
sign_in  in  1  sign of result (1 = negative)
out_valid  out  1  fp_out valid
out_ready  in  1  consumer accepts fp_out this cycle
fp_out  out  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}

Behaviour:
- Reset: one clock and reset. Reset is synchronous and active-low (aclr_n). While aclr_n=0 at a clock edge, all stage valid bits clear. out_valid=0 and fp_out=32'h0 after that edge. Reset overrides clk_en. Reset mid-operation discards all in-flight items; no partial output is ever presented.
- Advance condition: adv = clk_en & (~out_valid | out_ready).
- in_ready = adv, combinational. A transfer occurs when in_valid & in_ready.
- The pipeline moves only when adv=1. It is a global stall: every stage holds when adv=0, including bubbles.
- Stage 1 (capture): register fix_in, sign_in and the valid bit. Valid is written as in_valid&in_ready.
- Stage 2 (detect/normalise):
  - lz = count of leading zeros of the stage-1 value (0..31).
  - zero flag set when the value is 0.
  - norm = value << lz; norm[31]=1 when nonzero.
  - exp_pre = EXP_BIAS - lz, 8-bit, range 96..127.
- Stage 3 (round/pack):
  - mant = norm[30:8]
  - guard = norm[7]
  - sticky = |norm[6:0]
  - Round up when guard & (sticky | mant[0]).
  - If mant=all-ones and a round-up occurs: mant becomes 0 and exp becomes exp_pre+1.
  - fp_out = {sign, exp, mant}, registered with out_valid.
- Zero input: fp_out = 32'h00000000 regardless of sign_in (no -0).
- No denormals, infinities or NaNs are produced. The exponent range is 96..128 by construction.
- Latency: 3 adv-cycles from accepted input to out_valid. Throughput is 1 item per cycle when out_ready stays 1.
- Output hold: while out_valid=1 & out_ready=0, fp_out and out_valid hold stable, and in_ready=0.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: output pops and input is accepted on the same edge, with no bubble.
- clk_en=0: in_ready=0, all registers hold, and out_valid holds its value.
- Items leave in acceptance order. None are dropped or duplicated.

Test Plan:
- Reset then basic conversion, out_ready=1: feed the following and expect each one 3 cycles after acceptance.
  - 0x80000000, sign 0 -> 0x3F800000
  - 0x40000000 -> 0x3F000000
  - 0x00000001 -> 0x30000000
  - 0x00000000 with sign_in=1 -> 0x00000000
  - 0x80000000 with sign_in=1 -> 0xBF800000
- Rounding: feed the following.
  - 0x4DBA76D4 -> 0x3F1B74EE (guard=1, sticky=1, round up)
  - 0x80000180 -> 0x3F800002 (tie, odd LSB, round up)
  - 0x80000080 -> 0x3F800000 (tie, even LSB, round down)
  - 0xFFFFFFFF -> 0x40000000 (mantissa carry into exponent)
- Back-to-back streaming: 8 consecutive inputs with in_valid held high and out_ready=1. Expect out_valid high on 8 consecutive cycles starting at cycle 3, in order, with in_ready constantly 1.
- Backpressure: stream 5 inputs with out_ready=0. Expect in_ready to drop after 3 accepts, fp_out to hold its first value stable, and no accepts while stalled. Raising out_ready drains all accepted items in order, none lost.
- clk_en and reset: deassert clk_en mid-stream and check that all outputs freeze for 4 cycles and resume correctly. Pull aclr_n low for 1 cycle with 3 items in flight. Expect out_valid=0 and fp_out=0 after that edge, and none of those items to emerge afterwards.

Source files
------------

// File: rtl/cordic_fix2fp_pipe_if.sv
// Valid/ready stream bundle for the CORDIC fixed-to-float converter:
// fixed-point magnitude and sign in, IEEE-754 single out.
`timescale 1ns/1ps
interface cordic_fix2fp_pipe_if #(
  parameter int unsigned FIX_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [FIX_W-1:0] fix_in;
  logic             sign_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      fp_out;

  // Producer/consumer side: drives inputs and out_ready.
  modport master (
    output in_valid, fix_in, sign_in, out_ready,
    input  in_ready, out_valid, fp_out
  );

  // Converter side.
  modport slave (
    input  in_valid, fix_in, sign_in, out_ready,
    output in_ready, out_valid, fp_out
  );
endinterface

// File: rtl/cordic_fix2fp_pipe.sv
// Three-stage converter from unsigned Q1.(FIX_W-1) magnitude plus sign to
// IEEE-754 single: capture, leading-one normalise, round-to-nearest-even/pack.
`timescale 1ns/1ps
module cordic_fix2fp_pipe #(
  parameter int unsigned FIX_W    = 32,
  parameter int unsigned EXP_BIAS = 127
) (
  input logic                 clock,
  input logic                 aclr_n,
  input logic                 clk_en,
  cordic_fix2fp_pipe_if.slave bus
);

  localparam int unsigned LZ_W    = $clog2(FIX_W + 1);
  localparam int unsigned NORM_W  = (FIX_W < 32) ? 32 : FIX_W;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned MANT_CW = MANT_W + 1;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FP_W    = 32;

  logic adv;

  logic             s1_valid;
  logic             s1_sign;
  logic [FIX_W-1:0] s1_fix;

  logic [LZ_W-1:0]   s1_lz;
  logic [NORM_W-1:0] s1_align;
  logic [NORM_W-1:0] s1_norm;
  logic [EXP_W-1:0]  s1_exp;

  logic              s2_valid;
  logic              s2_sign;
  logic              s2_zero;
  logic [EXP_W-1:0]  s2_exp;
  logic [NORM_W-2:0] s2_frac;

  logic [MANT_W-1:0]  s2_mant;
  logic               s2_guard;
  logic               s2_sticky;
  logic               s2_round_up;
  logic [MANT_CW-1:0] s2_mant_sum;
  logic [EXP_W-1:0]   s2_exp_rnd;
  logic [FP_W-1:0]    s2_fp;

  logic            out_valid_q;
  logic [FP_W-1:0] fp_q;

  // Global stall: every stage, bubbles included, moves only on adv.
  assign adv          = clk_en & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.fp_out    = fp_q;

  // Stage 1: capture.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_fix   <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid & adv;
      s1_sign  <= bus.sign_in;
      s1_fix   <= bus.fix_in;
    end
  end

  // Leading-zero count: the highest set bit is visited last and wins.
  always_comb begin
    s1_lz = LZ_W'(FIX_W);
    for (int i = 0; i < int'(FIX_W); i++) begin
      if (s1_fix[i]) begin
        s1_lz = LZ_W'(int'(FIX_W) - 1 - i);
      end
    end
  end

  // Left-align into at least 32 bits so the rounding taps are fixed positions.
  always_comb begin
    s1_align = NORM_W'(s1_fix) << (NORM_W - FIX_W);
    s1_norm  = s1_align << s1_lz;
    s1_exp   = EXP_W'(EXP_BIAS - 32'(s1_lz));
  end

  // Stage 2: normalised fraction; a clear MSB after shifting means zero input.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= ~s1_norm[NORM_W-1];
      s2_exp   <= s1_exp;
      s2_frac  <= s1_norm[NORM_W-2:0];
    end
  end

  // Round to nearest even; an all-ones mantissa carries into the exponent.
  always_comb begin
    s2_mant     = s2_frac[NORM_W-2 -: MANT_W];
    s2_guard    = s2_frac[NORM_W-MANT_W-2];
    s2_sticky   = |s2_frac[NORM_W-MANT_W-3:0];
    s2_round_up = s2_guard & (s2_sticky | s2_mant[0]);
    s2_mant_sum = {1'b0, s2_mant} + MANT_CW'(s2_round_up);
    s2_exp_rnd  = s2_exp + EXP_W'(s2_mant_sum[MANT_W]);
    s2_fp       = s2_zero ? '0 : {s2_sign, s2_exp_rnd, s2_mant_sum[MANT_W-1:0]};
  end

  // Stage 3: output register; bubbles present zero.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      out_valid_q <= 1'b0;
      fp_q        <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid;
      fp_q        <= s2_valid ? s2_fp : '0;
    end
  end

endmodule

// File: tb/tb_cordic_fix2fp_pipe.sv
// Bench for cordic_fix2fp_pipe: vector table, random stream against a
// reference model, backpressure, clock-enable freeze and mid-flight reset.
`timescale 1ns/1ps
module tb_cordic_fix2fp_pipe;
  localparam int unsigned FIX_W = 32;

  logic clock = 1'b0;
  logic aclr_n;
  logic clk_en;

  cordic_fix2fp_pipe_if #(.FIX_W(FIX_W)) bus ();

  cordic_fix2fp_pipe #(.FIX_W(FIX_W), .EXP_BIAS(127)) dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] fix; logic sign; logic [31:0] fp; } vec_t;
  typedef struct { logic [31:0] fp; int acc_cyc; } sb_t;

  sb_t         sbq[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b0;
  logic [31:0] drv_exp  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: locate MSB, shift to 24 bits and round on the remainder.
  function automatic logic [31:0] ref_fp(input logic [31:0] v, input logic s);
    int p;
    int e;
    longint unsigned m, rem, half;
    if (v == 32'h0) return 32'h0;
    p = 31;
    while (!v[p]) p--;
    e = 127 + p - 31;
    if (p > 23) begin
      m    = 64'(v) >> (p - 23);
      rem  = 64'(v) & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e++;
      end
    end else begin
      m = 64'(v) << (23 - p);
    end
    return {s, 8'(e), m[22:0]};
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle(output bit acc);
    sb_t e;
    @(negedge clock);
    if (bus.out_valid && bus.out_ready && clk_en && aclr_n) begin
      if (sbq.size() == 0) begin
        check("spurious_output", bus.fp_out, 32'hDEAD_BEEF);
      end else begin
        e = sbq.pop_front();
        check("fp_out", bus.fp_out, e.fp);
        if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd3);
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) sbq.push_back('{fp: drv_exp, acc_cyc: cyc});
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drain(input int max_cyc);
    bit a;
    bus.in_valid = 1'b0;
    for (int i = 0; i < max_cyc && sbq.size() > 0; i++) cycle(a);
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a;
    vec_t        tv[9];
    logic [31:0] v;
    logic        s;
    int          idx;
    logic [31:0] bp_fix[5];
    logic        bp_sign[5];

    tv[0] = '{32'h8000_0000, 1'b0, 32'h3F80_0000};
    tv[1] = '{32'h4000_0000, 1'b0, 32'h3F00_0000};
    tv[2] = '{32'h0000_0001, 1'b0, 32'h3000_0000};
    tv[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000};
    tv[4] = '{32'h8000_0000, 1'b1, 32'hBF80_0000};
    tv[5] = '{32'h4DBA_76D4, 1'b0, 32'h3F1B_74EE};
    tv[6] = '{32'h8000_0180, 1'b0, 32'h3F80_0002};
    tv[7] = '{32'h8000_0080, 1'b0, 32'h3F80_0000};
    tv[8] = '{32'hFFFF_FFFF, 1'b0, 32'h4000_0000};

    aclr_n        = 1'b0;
    clk_en        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.fix_in    = '0;
    bus.sign_in   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    cycle(a);
    cycle(a);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fp_out", bus.fp_out, 32'h0);
    aclr_n        = 1'b1;
    bus.out_ready = 1'b1;
    cycle(a);

    // Directed vector table, back to back
    lat_chk = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.fix_in   = tv[i].fix;
      bus.sign_in  = tv[i].sign;
      drv_exp      = tv[i].fp;
      cycle(a);
      check("tbl_accept", 32'(a), 32'd1);
    end
    drain(10);

    // Random streaming against the reference model
    for (int i = 0; i < 8; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      bus.fix_in   = v;
      bus.sign_in  = s;
      drv_exp      = ref_fp(v, s);
      cycle(a);
      check("stream_in_ready", 32'(a), 32'd1);
    end
    drain(10);

    // Backpressure: 5 items offered with the consumer stalled
    lat_chk       = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_fix[i]  = $urandom | 32'h0000_0100;
      bp_sign[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.fix_in   = bp_fix[idx];
      bus.sign_in  = bp_sign[idx];
      drv_exp      = ref_fp(bp_fix[idx], bp_sign[idx]);
      cycle(a);
      if (a) idx++;
      if (c >= 2) begin
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data", bus.fp_out, ref_fp(bp_fix[0], bp_sign[0]));
      end
    end
    check("bp_accepts", 32'(idx), 32'd3);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 10 && idx < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.fix_in   = bp_fix[idx];
      bus.sign_in  = bp_sign[idx];
      drv_exp      = ref_fp(bp_fix[idx], bp_sign[idx]);
      cycle(a);
      if (c == 0) check("bp_pop_and_accept", 32'(a), 32'd1);
      if (a) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'd5);
    drain(10);

    // Clock-enable freeze mid-stream
    idx = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      v = $urandom >> $urandom_range(0, 8);
      bus.in_valid = 1'b1;
      bus.fix_in   = v;
      bus.sign_in  = 1'b0;
      drv_exp      = ref_fp(v, 1'b0);
      cycle(a);
      if (a) idx++;
      if (idx == 4 && clk_en) begin
        clk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
          #1;
          check("en_in_ready", 32'(bus.in_ready), 32'd0);
          cycle(a);
          check("en_no_accept", 32'(a), 32'd0);
          check("en_hold_valid", 32'(bus.out_valid), 32'd1);
          check("en_hold_data", bus.fp_out, sbq[0].fp);
        end
        clk_en = 1'b1;
      end
    end
    check("en_all_accepted", 32'(idx), 32'd6);
    drain(10);

    // Reset with three items in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = $urandom | 32'h1;
      bus.in_valid = 1'b1;
      bus.fix_in   = v;
      bus.sign_in  = 1'b1;
      drv_exp      = ref_fp(v, 1'b1);
      cycle(a);
      check("rip_accept", 32'(a), 32'd1);
    end
    bus.in_valid = 1'b0;
    aclr_n       = 1'b0;
    cycle(a);
    sbq.delete();
    check("rip_out_valid", 32'(bus.out_valid), 32'd0);
    check("rip_fp_out", bus.fp_out, 32'h0);
    aclr_n        = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(a);
      check("rip_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Recovery after reset
    lat_chk      = 1'b1;
    bus.in_valid = 1'b1;
    bus.fix_in   = tv[5].fix;
    bus.sign_in  = tv[5].sign;
    drv_exp      = tv[5].fp;
    cycle(a);
    check("rec_accept", 32'(a), 32'd1);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
